int_ctrl: RTL and testbench

External interrupt controller feeding the pipelined CPU's `INT` input and exception cause logic. It collects up to `N_SRC` device interrupt lines and latches edge or level requests into a pending register. It applies a per-source mask, picks the lowest-numbered unmasked pending source, and holds one request until the CPU acknowledges trap entry. It blocks further requests until the handler retires `MRET` (end-of-interrupt), matching the CPU's single-level, non-nested exception model.

---
 rtl/int_ctrl_pkg.sv | 18 +
 rtl/int_src_cell.sv | 59 +++++
 rtl/int_ctrl.sv | 139 +++++++++++++
 tb/tb_int_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/int_ctrl_pkg.sv
// rtl/int_ctrl_pkg.sv - shared types and constants for the external interrupt controller
//
// Purpose: FSM state encoding, cause base value and default source count,
//          imported by int_src_cell and int_ctrl.
// Ports:   none (package).
// Build option: INT_CTRL_SYNC_EN (consumed by int_src_cell).
package int_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  localparam logic [7:0] INT_CAUSE_BASE = 8'h80;
  localparam int         N_SRC_DEFAULT  = 8;

endpackage

// File: rtl/int_src_cell.sv
// rtl/int_src_cell.sv - per-source conditioning, edge history and pending flop
//
// Purpose: conditions one raw interrupt line and maintains its pending bit.
//          Edge mode: set on a 0->1 of the conditioned line, cleared by i_clr,
//          set beats clear. Level mode: pending follows the conditioned line.
// Build option: INT_CTRL_SYNC_EN inserts a 2-flop synchronizer (reset 0)
//          in front of the edge detect and level sampling.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   i_irq        raw device line
//   i_edge_sel   1 = rising-edge, 0 = level
//   i_clr        acknowledge of this source (edge mode only)
//   o_pending    pending bit
module int_src_cell
  import int_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_irq,
  input  logic i_edge_sel,
  input  logic i_clr,
  output logic o_pending
);

  logic w_line;
  logic r_hist;
  logic r_pending;

`ifdef INT_CTRL_SYNC_EN
  logic [1:0] r_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_sync <= 2'b00;
    else       r_sync <= {r_sync[0], i_irq};
  end

  assign w_line = r_sync[1];
`else
  assign w_line = i_irq;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hist    <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_hist <= w_line;
      if (!i_edge_sel)
        r_pending <= w_line;
      else if (w_line && !r_hist)
        r_pending <= 1'b1;   // a fresh edge must not be lost to a same-cycle ack
      else if (i_clr)
        r_pending <= 1'b0;
    end
  end

  assign o_pending = r_pending;

endmodule

// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - single-level external interrupt controller for the CPU INT input
//
// Purpose: latches up to N_SRC edge/level requests, masks them, raises INT for
//          the lowest-numbered unmasked pending source, holds it until int_ack,
//          then blocks new requests until int_eoi (MRET).
// Build option: INT_CTRL_SYNC_EN (synchronizers in int_src_cell).
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   irq_src[N_SRC]          raw device lines
//   edge_sel[N_SRC]         1 = edge, 0 = level per source
//   mask_we, mask_wdata     mask register write (1 = enabled)
//   int_ack, int_eoi        trap entry / MRET pulses
//   INT, int_id, int_cause  registered request, source index, 8'h80|id
//   int_pending, int_mask   pending register (unmasked view), mask register
//   in_service              high while a handler runs
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEFAULT,
  parameter int ID_W  = (N_SRC > 2) ? $clog2(N_SRC) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_src,
  input  logic [N_SRC-1:0] edge_sel,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  input  logic             int_ack,
  input  logic             int_eoi,
  output logic             INT,
  output logic [ID_W-1:0]  int_id,
  output logic [7:0]       int_cause,
  output logic [N_SRC-1:0] int_pending,
  output logic [N_SRC-1:0] int_mask,
  output logic             in_service
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [ID_W-1:0]  r_id;
  logic [ID_W-1:0]  w_id_nxt;
  logic [ID_W-1:0]  w_low_id;
  logic             w_any;
  logic             r_int;
  logic             r_in_service;
  logic [7:0]       r_cause;
  logic [N_SRC-1:0] r_mask;
  logic [N_SRC-1:0] w_pending;
  logic [N_SRC-1:0] w_active;
  logic [N_SRC-1:0] w_clr;

  // Ack only clears the latched source, and only while a request is outstanding.
  always_comb begin
    w_clr = '0;
    for (int i = 0; i < N_SRC; i++)
      w_clr[i] = int_ack && (r_state == ST_REQ) && (r_id == ID_W'(i));
  end

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    int_src_cell u_cell (
      .clk        (clk),
      .reset      (reset),
      .i_irq      (irq_src[g]),
      .i_edge_sel (edge_sel[g]),
      .i_clr      (w_clr[g]),
      .o_pending  (w_pending[g])
    );
  end

  // Mask register: a write lands at the edge, so this cycle's decision sees the old mask.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        r_mask <= '1;
    else if (mask_we) r_mask <= mask_wdata;
  end

  assign w_active = w_pending & r_mask;
  assign w_any    = |w_active;

  // Lowest index wins: scan from the top so the last hit is the smallest.
  always_comb begin
    w_low_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--)
      if (w_active[i]) w_low_id = ID_W'(i);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_id_nxt    = r_id;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nxt = ST_REQ;
          w_id_nxt    = w_low_id;
        end
      end
      ST_REQ: begin
        if (int_ack)
          w_state_nxt = ST_SERVICE;
        else if (!w_active[r_id])
          w_state_nxt = ST_IDLE;   // source masked or level released: withdraw
      end
      ST_SERVICE: begin
        if (int_eoi) begin
          if (w_any) begin
            w_state_nxt = ST_REQ;
            w_id_nxt    = w_low_id;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_id         <= '0;
      r_int        <= 1'b0;
      r_in_service <= 1'b0;
      r_cause      <= INT_CAUSE_BASE;
    end else begin
      r_state      <= w_state_nxt;
      r_id         <= w_id_nxt;
      r_int        <= (w_state_nxt == ST_REQ);
      r_in_service <= (w_state_nxt == ST_SERVICE);
      r_cause      <= INT_CAUSE_BASE | 8'(w_id_nxt);
    end
  end

  assign INT         = r_int;
  assign int_id      = r_id;
  assign int_cause   = r_cause;
  assign int_pending = w_pending;
  assign int_mask    = r_mask;
  assign in_service  = r_in_service;

endmodule

// File: tb/tb_int_ctrl.sv
// tb/tb_int_ctrl.sv - self-checking bench for int_ctrl
module tb_int_ctrl;

  logic       clk;
  logic       reset;
  logic [7:0] irq_src;
  logic [7:0] edge_sel;
  logic       mask_we;
  logic [7:0] mask_wdata;
  logic       int_ack;
  logic       int_eoi;
  logic       INT;
  logic [2:0] int_id;
  logic [7:0] int_cause;
  logic [7:0] int_pending;
  logic [7:0] int_mask;
  logic       in_service;

  int checks = 0;
  int errors = 0;

  int_ctrl #(.N_SRC(8), .ID_W(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .irq_src     (irq_src),
    .edge_sel    (edge_sel),
    .mask_we     (mask_we),
    .mask_wdata  (mask_wdata),
    .int_ack     (int_ack),
    .int_eoi     (int_eoi),
    .INT         (INT),
    .int_id      (int_id),
    .int_cause   (int_cause),
    .int_pending (int_pending),
    .int_mask    (int_mask),
    .in_service  (in_service)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] irq;
    logic       mwe;
    logic [7:0] mwd;
    logic       ack;
    logic       eoi;
    logic       e_int;
    logic [2:0] e_id;
    logic [7:0] e_pend;
    logic [7:0] e_mask;
    logic       e_svc;
  } vec_t;

  vec_t vecs [51];
  vec_t exp_q [$];

  function automatic vec_t v(input logic [7:0] irq, input logic mwe, input logic [7:0] mwd,
                             input logic ack, input logic eoi, input logic e_int,
                             input logic [2:0] e_id, input logic [7:0] e_pend,
                             input logic [7:0] e_mask, input logic e_svc);
    vec_t r;
    r.irq = irq; r.mwe = mwe; r.mwd = mwd; r.ack = ack; r.eoi = eoi;
    r.e_int = e_int; r.e_id = e_id; r.e_pend = e_pend; r.e_mask = e_mask; r.e_svc = e_svc;
    return r;
  endfunction

  task automatic chk(input string name, input int row, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h want %0h", name, row, act, exp);
    end
  endtask

  task automatic compare_front(input int row);
    vec_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard row %0d: got empty want entry", row);
    end else begin
      e = exp_q.pop_front();
      chk("INT",        row, {7'd0, INT},        {7'd0, e.e_int});
      chk("int_id",     row, {5'd0, int_id},     {5'd0, e.e_id});
      chk("int_cause",  row, int_cause,          8'h80 | {5'd0, e.e_id});
      chk("int_pending",row, int_pending,        e.e_pend);
      chk("int_mask",   row, int_mask,           e.e_mask);
      chk("in_service", row, {7'd0, in_service}, {7'd0, e.e_svc});
    end
  endtask

  task automatic step(input vec_t x, input int row);
    irq_src    = x.irq;
    mask_we    = x.mwe;
    mask_wdata = x.mwd;
    int_ack    = x.ack;
    int_eoi    = x.eoi;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    compare_front(row);
  endtask

  initial begin
    // edge sources everywhere except source 1 (level)
    edge_sel   = 8'hFD;
    reset      = 1'b1;
    irq_src    = 8'h00;
    mask_we    = 1'b0;
    mask_wdata = 8'h00;
    int_ack    = 1'b0;
    int_eoi    = 1'b0;

    //            irq  mwe mwd  ack eoi | INT id pend mask svc
    // edge source 3
    vecs[0]  = v(8'h00,0,8'h00,0,0, 0,3'd0,8'h00,8'hFF,0);
    vecs[1]  = v(8'h08,0,8'h00,0,0, 0,3'd0,8'h08,8'hFF,0);
    vecs[2]  = v(8'h00,0,8'h00,0,0, 1,3'd3,8'h08,8'hFF,0);
    vecs[3]  = v(8'h00,0,8'h00,1,0, 0,3'd3,8'h00,8'hFF,1);
    vecs[4]  = v(8'h00,0,8'h00,0,1, 0,3'd3,8'h00,8'hFF,0);
    // sources 5 and 2 together
    vecs[5]  = v(8'h24,0,8'h00,0,0, 0,3'd3,8'h24,8'hFF,0);
    vecs[6]  = v(8'h00,0,8'h00,0,0, 1,3'd2,8'h24,8'hFF,0);
    vecs[7]  = v(8'h00,0,8'h00,1,0, 0,3'd2,8'h20,8'hFF,1);
    vecs[8]  = v(8'h00,0,8'h00,0,0, 0,3'd2,8'h20,8'hFF,1);
    vecs[9]  = v(8'h00,0,8'h00,0,1, 1,3'd5,8'h20,8'hFF,0);
    vecs[10] = v(8'h00,0,8'h00,1,0, 0,3'd5,8'h00,8'hFF,1);
    vecs[11] = v(8'h00,0,8'h00,0,1, 0,3'd5,8'h00,8'hFF,0);
    // level source 1, masked during REQ
    vecs[12] = v(8'h02,0,8'h00,0,0, 0,3'd5,8'h02,8'hFF,0);
    vecs[13] = v(8'h02,0,8'h00,0,0, 1,3'd1,8'h02,8'hFF,0);
    vecs[14] = v(8'h02,1,8'hFD,0,0, 1,3'd1,8'h02,8'hFD,0);
    vecs[15] = v(8'h02,0,8'h00,0,0, 0,3'd1,8'h02,8'hFD,0);
    vecs[16] = v(8'h02,0,8'h00,0,0, 0,3'd1,8'h02,8'hFD,0);
    vecs[17] = v(8'h02,1,8'hFF,0,0, 0,3'd1,8'h02,8'hFF,0);
    vecs[18] = v(8'h02,0,8'h00,0,0, 1,3'd1,8'h02,8'hFF,0);
    vecs[19] = v(8'h02,0,8'h00,1,0, 0,3'd1,8'h02,8'hFF,1);
    vecs[20] = v(8'h00,0,8'h00,0,0, 0,3'd1,8'h00,8'hFF,1);
    vecs[21] = v(8'h00,0,8'h00,0,1, 0,3'd1,8'h00,8'hFF,0);
    // level release withdraws the request
    vecs[22] = v(8'h02,0,8'h00,0,0, 0,3'd1,8'h02,8'hFF,0);
    vecs[23] = v(8'h00,0,8'h00,0,0, 1,3'd1,8'h00,8'hFF,0);
    vecs[24] = v(8'h00,0,8'h00,0,0, 0,3'd1,8'h00,8'hFF,0);
    // source 0: eoi ignored in REQ, re-edge during SERVICE, ack ignored in SERVICE
    vecs[25] = v(8'h01,0,8'h00,0,0, 0,3'd1,8'h01,8'hFF,0);
    vecs[26] = v(8'h00,0,8'h00,0,1, 1,3'd0,8'h01,8'hFF,0);
    vecs[27] = v(8'h00,0,8'h00,0,1, 1,3'd0,8'h01,8'hFF,0);
    vecs[28] = v(8'h00,0,8'h00,1,0, 0,3'd0,8'h00,8'hFF,1);
    vecs[29] = v(8'h01,0,8'h00,0,0, 0,3'd0,8'h01,8'hFF,1);
    vecs[30] = v(8'h01,0,8'h00,1,0, 0,3'd0,8'h01,8'hFF,1);
    vecs[31] = v(8'h00,0,8'h00,0,1, 1,3'd0,8'h01,8'hFF,0);
    vecs[32] = v(8'h00,0,8'h00,1,0, 0,3'd0,8'h00,8'hFF,1);
    vecs[33] = v(8'h00,0,8'h00,0,1, 0,3'd0,8'h00,8'hFF,0);
    // source 4: new edge in the ack cycle, set wins
    vecs[34] = v(8'h10,0,8'h00,0,0, 0,3'd0,8'h10,8'hFF,0);
    vecs[35] = v(8'h00,0,8'h00,0,0, 1,3'd4,8'h10,8'hFF,0);
    vecs[36] = v(8'h10,0,8'h00,1,0, 0,3'd4,8'h10,8'hFF,1);
    vecs[37] = v(8'h00,0,8'h00,0,1, 1,3'd4,8'h10,8'hFF,0);
    vecs[38] = v(8'h00,0,8'h00,1,0, 0,3'd4,8'h00,8'hFF,1);
    vecs[39] = v(8'h00,0,8'h00,0,1, 0,3'd4,8'h00,8'hFF,0);
    // ack and eoi together: state picks which acts
    vecs[40] = v(8'h08,0,8'h00,0,0, 0,3'd4,8'h08,8'hFF,0);
    vecs[41] = v(8'h00,0,8'h00,0,0, 1,3'd3,8'h08,8'hFF,0);
    vecs[42] = v(8'h00,0,8'h00,1,1, 0,3'd3,8'h00,8'hFF,1);
    vecs[43] = v(8'h00,0,8'h00,1,1, 0,3'd3,8'h00,8'hFF,0);
    // masked source 0 latches but loses to 6; old mask used on eoi
    vecs[44] = v(8'h00,1,8'hFE,0,0, 0,3'd3,8'h00,8'hFE,0);
    vecs[45] = v(8'h41,0,8'h00,0,0, 0,3'd3,8'h41,8'hFE,0);
    vecs[46] = v(8'h00,0,8'h00,0,0, 1,3'd6,8'h41,8'hFE,0);
    vecs[47] = v(8'h00,0,8'h00,1,0, 0,3'd6,8'h01,8'hFE,1);
    vecs[48] = v(8'h00,1,8'hFF,0,1, 0,3'd6,8'h01,8'hFF,0);
    vecs[49] = v(8'h00,0,8'h00,0,0, 1,3'd0,8'h01,8'hFF,0);
    vecs[50] = v(8'h00,1,8'hFE,0,0, 1,3'd0,8'h01,8'hFE,0);

    repeat (2) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    exp_q.push_back(v(8'h00,0,8'h00,0,0, 0,3'd0,8'h00,8'hFF,0));
    compare_front(-1);

    for (int i = 0; i < 51; i++)
      step(vecs[i], i);

    // asynchronous reset while INT is high, away from any clock edge
    #2;
    reset = 1'b1;
    #1;
    exp_q.push_back(v(8'h00,0,8'h00,0,0, 0,3'd0,8'h00,8'hFF,0));
    compare_front(100);
    @(posedge clk);
    #2;
    reset = 1'b0;
    step(v(8'h00,0,8'h00,0,0, 0,3'd0,8'h00,8'hFF,0), 101);
    // highest index source after reset
    step(v(8'h80,0,8'h00,0,0, 0,3'd0,8'h80,8'hFF,0), 102);
    step(v(8'h00,0,8'h00,0,0, 1,3'd7,8'h80,8'hFF,0), 103);
    step(v(8'h00,0,8'h00,1,0, 0,3'd7,8'h00,8'hFF,1), 104);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
